// File: rtl/main_ram_arb.sv
// Banked 32-bit main RAM with two requestor ports: A (CPU/bus) and B (video/DMA fetch).
// Same-bank conflicts use round-robin. Define MAIN_RAM_STALL_CNT_EN to build the port B stall counter.
module main_ram_arb #(
    parameter int NUM_BANKS    = 2,
    parameter int BANK_DEPTH   = 16384,
    parameter int BANK_SEL_LOW = 0,
    parameter int OUT_REG      = 0,
    localparam int BANK_W      = $clog2(NUM_BANKS),
    localparam int ROW_W       = $clog2(BANK_DEPTH),
    localparam int ADDR_W      = BANK_W + ROW_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    output logic              a_ack,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_write,
    input  logic [31:0]       a_wrdata,
    input  logic [3:0]        a_wrbytesel,
    output logic [31:0]       a_rddata,
    output logic              a_rdvalid,
    input  logic              b_req,
    output logic              b_ack,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_write,
    input  logic [31:0]       b_wrdata,
    input  logic [3:0]        b_wrbytesel,
    output logic [31:0]       b_rddata,
    output logic              b_rdvalid,
    output logic [15:0]       b_stall_cnt
);

    // state | meaning
    // RR_A  | port A wins the next same-bank conflict
    // RR_B  | port B wins the next same-bank conflict
    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_e;

    localparam int IDX_W = (BANK_W > 0) ? BANK_W : 1;

    rr_e              rr_q, rr_d;
    logic             conflict;
    logic [IDX_W-1:0] a_bank, b_bank;
    logic [ROW_W-1:0] a_row, b_row;
    logic             a_rd_q, a_rd_d, b_rd_q, b_rd_d;
    logic [IDX_W-1:0] a_bsel_q, b_bsel_q;
    logic [31:0]      bank_rdata [NUM_BANKS];
    logic [31:0]      a_ret, b_ret;

    // Bank/row split of the word address.
    generate
        if (NUM_BANKS == 1) begin : g_dec_one
            assign a_bank = '0;
            assign b_bank = '0;
            assign a_row  = a_addr;
            assign b_row  = b_addr;
        end else if (BANK_SEL_LOW != 0) begin : g_dec_low
            assign a_bank = a_addr[BANK_W-1:0];
            assign b_bank = b_addr[BANK_W-1:0];
            assign a_row  = a_addr[ADDR_W-1:BANK_W];
            assign b_row  = b_addr[ADDR_W-1:BANK_W];
        end else begin : g_dec_high
            assign a_bank = a_addr[ADDR_W-1 -: BANK_W];
            assign b_bank = b_addr[ADDR_W-1 -: BANK_W];
            assign a_row  = a_addr[ROW_W-1:0];
            assign b_row  = b_addr[ROW_W-1:0];
        end
    endgenerate

    always_comb begin
        conflict = 1'b0;
        a_ack    = 1'b0;
        b_ack    = 1'b0;
        rr_d     = rr_q;
        if (!rst) begin
            conflict = a_req & b_req & (a_bank == b_bank);
            a_ack    = a_req & (~conflict | (rr_q == RR_A));
            b_ack    = b_req & (~conflict | (rr_q == RR_B));
            // Pointer only moves on a conflict, and always towards the loser.
            if (conflict) begin
                rr_d = (rr_q == RR_A) ? RR_B : RR_A;
            end
        end
    end

    always_comb begin
        a_rd_d = a_ack & ~a_write;
        b_rd_d = b_ack & ~b_write;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q     <= RR_A;
            a_rd_q   <= 1'b0;
            b_rd_q   <= 1'b0;
            a_bsel_q <= '0;
            b_bsel_q <= '0;
        end else begin
            rr_q     <= rr_d;
            a_rd_q   <= a_rd_d;
            b_rd_q   <= b_rd_d;
            a_bsel_q <= a_bank;
            b_bsel_q <= b_bank;
        end
    end

    generate
        for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
            logic [31:0]      mem [BANK_DEPTH];
            logic             sel_a, sel_b, en, we;
            logic [ROW_W-1:0] row;
            logic [31:0]      wdata;
            logic [3:0]       wmask;
            logic [31:0]      rdata_q;

            // Acks are already exclusive per bank, so a plain priority mux suffices.
            assign sel_a = a_ack & (a_bank == IDX_W'(k));
            assign sel_b = b_ack & (b_bank == IDX_W'(k));
            assign en    = sel_a | sel_b;
            assign we    = (sel_a & a_write) | (sel_b & b_write);
            assign row   = sel_b ? b_row : a_row;
            assign wdata = sel_b ? b_wrdata : a_wrdata;
            assign wmask = sel_b ? b_wrbytesel : a_wrbytesel;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        for (int i = 0; i < 4; i++) begin
                            if (wmask[i]) begin
                                mem[row][8*i +: 8] <= wdata[8*i +: 8];
                            end
                        end
                    end
                    rdata_q <= mem[row];
                end
            end

            assign bank_rdata[k] = rdata_q;
        end
    endgenerate

    assign a_ret = bank_rdata[a_bsel_q];
    assign b_ret = bank_rdata[b_bsel_q];

    generate
        if (OUT_REG == 0) begin : g_out_direct
            logic [31:0] a_hold_q, b_hold_q;

            assign a_rdvalid = a_rd_q & ~rst;
            assign b_rdvalid = b_rd_q & ~rst;
            assign a_rddata  = a_rdvalid ? a_ret : a_hold_q;
            assign b_rddata  = b_rdvalid ? b_ret : b_hold_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_hold_q <= '0;
                    b_hold_q <= '0;
                end else begin
                    if (a_rdvalid) a_hold_q <= a_ret;
                    if (b_rdvalid) b_hold_q <= b_ret;
                end
            end
        end else begin : g_out_reg
            logic        a_vld_q, b_vld_q;
            logic [31:0] a_dat_q, b_dat_q;

            assign a_rdvalid = a_vld_q & ~rst;
            assign b_rdvalid = b_vld_q & ~rst;
            assign a_rddata  = a_dat_q;
            assign b_rddata  = b_dat_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_vld_q <= 1'b0;
                    b_vld_q <= 1'b0;
                    a_dat_q <= '0;
                    b_dat_q <= '0;
                end else begin
                    a_vld_q <= a_rd_q;
                    b_vld_q <= b_rd_q;
                    if (a_rd_q) a_dat_q <= a_ret;
                    if (b_rd_q) b_dat_q <= b_ret;
                end
            end
        end
    endgenerate

`ifdef MAIN_RAM_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (b_req && !b_ack && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign b_stall_cnt = stall_q;
`else
    assign b_stall_cnt = 16'h0000;
`endif

endmodule
